// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART-facing line sender.
//   - line_state_e : FSM state encoding of ram_line_sender
//   - CHAR_CR/LF   : line terminator characters
//   - TERM_*       : terminator mode selectors for the TERM_MODE parameter
//   - term_entry() : first state after the data characters of a line
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      LOAD    = 3'd2,
      SEND    = 3'd3,
      TERM_CR = 3'd4,
      TERM_LF = 3'd5,
      DONE    = 3'd6
   } line_state_e;

   localparam logic [7:0] CHAR_CR = 8'h0D;
   localparam logic [7:0] CHAR_LF = 8'h0A;

   localparam int unsigned TERM_NONE    = 0;
   localparam int unsigned TERM_LF_ONLY = 1;
   localparam int unsigned TERM_CRLF    = 2;

   // State that follows the last data character (or an empty line):
   // CR for CR/LF mode, LF for LF-only mode, straight to DONE otherwise.
   function automatic line_state_e term_entry(input int unsigned mode);
      line_state_e st;
      case (mode)
         TERM_CRLF:    st = TERM_CR;
         TERM_LF_ONLY: st = TERM_LF;
         default:      st = DONE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/ram_line_sender_if.sv
// ---------------------------------------------------------------------------
// ram_line_sender_if
//   Bundles the control, RAM and UART signals of ram_line_sender.
//   Control : Start, Abort, BaseAddress, Length  (to the sender)
//   RAM     : RAMAddress (from sender), RAMData (to sender, 1-cycle latency)
//   UART    : TxFull, UartTick (to sender), TxData, WriteToUart (from sender)
//   Status  : Busy, Done (from sender)
//   master  : the environment driving requests and modelling RAM/UART
//   slave   : the sender itself
// ---------------------------------------------------------------------------
interface ram_line_sender_if #(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 8
);

   logic                  Start;
   logic                  Abort;
   logic [ADDR_WIDTH-1:0] BaseAddress;
   logic [ADDR_WIDTH-1:0] Length;
   logic [DATA_WIDTH-1:0] RAMData;
   logic                  TxFull;
   logic                  UartTick;
   logic [ADDR_WIDTH-1:0] RAMAddress;
   logic [DATA_WIDTH-1:0] TxData;
   logic                  WriteToUart;
   logic                  Busy;
   logic                  Done;

   modport master (
      output Start, Abort, BaseAddress, Length, RAMData, TxFull, UartTick,
      input  RAMAddress, TxData, WriteToUart, Busy, Done
   );

   modport slave (
      input  Start, Abort, BaseAddress, Length, RAMData, TxFull, UartTick,
      output RAMAddress, TxData, WriteToUart, Busy, Done
   );

endinterface

// File: rtl/ram_line_sender.sv
// ---------------------------------------------------------------------------
// ram_line_sender
//   Reads Length characters from an external synchronous RAM starting at
//   BaseAddress and writes them to a UART FIFO, followed by the terminator
//   selected by TERM_MODE (0 none, 1 LF, 2 CR LF).
//
//   Parameters : ADDR_WIDTH, DATA_WIDTH, TERM_MODE
//   Ports      : Clock   - system clock, rising edge
//                Reset_n - asynchronous active-low reset
//                bus     - ram_line_sender_if.slave (control, RAM, UART,
//                          status signals)
//
//   All outputs are registered. A character is written when the current
//   send state sees UartTick=1, TxFull=0 and no strobe in flight; the
//   strobe appears the following cycle with TxData held stable.
// ---------------------------------------------------------------------------
module ram_line_sender
   import uart_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TERM_MODE  = 2
) (
   input  logic              Clock,
   input  logic              Reset_n,
   ram_line_sender_if.slave  bus
);

   line_state_e           state_q,    state_d;
   logic [ADDR_WIDTH-1:0] base_q,     base_d;
   logic [ADDR_WIDTH-1:0] len_q,      len_d;
   logic [ADDR_WIDTH-1:0] count_q,    count_d;
   logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_WIDTH-1:0] tx_data_q,  tx_data_d;
   logic                  wr_q,       wr_d;
   logic                  busy_q,     busy_d;
   logic                  done_q,     done_d;
   logic                  term_ld_q,  term_ld_d;
   logic                  fire;

   // Blocking fire while a strobe is out keeps strobes two cycles apart.
   assign fire = bus.UartTick & ~bus.TxFull & ~wr_q;

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      count_d    = count_q;
      ram_addr_d = ram_addr_q;
      tx_data_d  = tx_data_q;
      term_ld_d  = term_ld_q;
      wr_d       = 1'b0;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.Start && !bus.Abort) begin
               base_d    = bus.BaseAddress;
               len_d     = bus.Length;
               count_d   = '0;
               term_ld_d = 1'b0;
               if (bus.Length != '0) begin
                  // Address is registered on entry so the RAM sees it for
                  // the whole ADDR cycle and returns data during LOAD.
                  ram_addr_d = bus.BaseAddress;
                  state_d    = ADDR;
               end else begin
                  state_d = term_entry(TERM_MODE);
               end
            end
         end

         ADDR: state_d = LOAD;

         LOAD: begin
            tx_data_d = bus.RAMData;
            state_d   = SEND;
         end

         SEND: begin
            if (fire) begin
               wr_d    = 1'b1;
               count_d = count_q + ADDR_WIDTH'(1);
               if (count_d < len_q) begin
                  ram_addr_d = base_q + count_d;
                  state_d    = ADDR;
               end else begin
                  term_ld_d = 1'b0;
                  state_d   = term_entry(TERM_MODE);
               end
            end
         end

         // Terminator states spend their first cycle loading the constant,
         // which leaves TxData untouched during the previous character's
         // strobe; they may fire from the second cycle on.
         TERM_CR: begin
            if (!term_ld_q) begin
               tx_data_d = DATA_WIDTH'(CHAR_CR);
               term_ld_d = 1'b1;
            end else if (fire) begin
               wr_d      = 1'b1;
               term_ld_d = 1'b0;
               state_d   = TERM_LF;
            end
         end

         TERM_LF: begin
            if (!term_ld_q) begin
               tx_data_d = DATA_WIDTH'(CHAR_LF);
               term_ld_d = 1'b1;
            end else if (fire) begin
               wr_d      = 1'b1;
               term_ld_d = 1'b0;
               state_d   = DONE;
            end
         end

         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase

      // Abort overrides every transition, including a same-cycle fire.
      if (bus.Abort && (state_q != IDLE)) begin
         state_d = IDLE;
         wr_d    = 1'b0;
         done_d  = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         count_q    <= '0;
         ram_addr_q <= '0;
         tx_data_q  <= '0;
         wr_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         term_ld_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         count_q    <= count_d;
         ram_addr_q <= ram_addr_d;
         tx_data_q  <= tx_data_d;
         wr_q       <= wr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         term_ld_q  <= term_ld_d;
      end
   end

   assign bus.RAMAddress  = ram_addr_q;
   assign bus.TxData      = tx_data_q;
   assign bus.WriteToUart = wr_q;
   assign bus.Busy        = busy_q;
   assign bus.Done        = done_q;

endmodule

// File: tb/tb_ram_line_sender.sv
// ---------------------------------------------------------------------------
// tb_ram_line_sender
//   Directed bench for ram_line_sender. u_dut runs CR/LF mode, u_dut_lf runs
//   LF-only mode. RAM contents are mem[i] = 8'h41 + 3*i, so expected
//   characters below are written out as literals.
// ---------------------------------------------------------------------------
module tb_ram_line_sender;

   logic Clock;
   logic Reset_n;

   int vectors     = 0;
   int miscompares = 0;

   ram_line_sender_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus ();
   ram_line_sender_if #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) bus_lf ();

   ram_line_sender #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .TERM_MODE(2)) u_dut (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   ram_line_sender #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .TERM_MODE(1)) u_dut_lf (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .bus     (bus_lf.slave)
   );

   logic [7:0] mem [64];

   always_ff @(posedge Clock) begin
      bus.RAMData <= mem[bus.RAMAddress];
   end

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   logic [7:0] got_tx   [$];
   int         got_cyc  [$];
   logic [5:0] got_addr [$];
   int         done_cyc;

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs the line started in the current cycle; cycle c is c edges after
   // the Start cycle. With poke set, a foreign Start is pulsed mid-line.
   task automatic collect(input int budget, input bit poke);
      logic [5:0] last_addr;
      got_tx.delete();
      got_cyc.delete();
      got_addr.delete();
      done_cyc  = -1;
      last_addr = '0;
      for (int c = 1; c <= budget; c++) begin
         if (poke && c == 5) begin
            bus.Start       = 1'b1;
            bus.BaseAddress = 6'h2A;
            bus.Length      = 6'd9;
         end
         if (poke && c == 6) bus.Start = 1'b0;
         step();
         if (c == 1) bus.Start = 1'b0;
         if (bus.WriteToUart) begin
            got_tx.push_back(bus.TxData);
            got_cyc.push_back(c);
         end
         if (c == 1 || bus.RAMAddress != last_addr) got_addr.push_back(bus.RAMAddress);
         last_addr = bus.RAMAddress;
         if (bus.Done) begin
            done_cyc = c;
            break;
         end
      end
   endtask

   task automatic start_line(input logic [5:0] base, input logic [5:0] len);
      bus.BaseAddress = base;
      bus.Length      = len;
      bus.Start       = 1'b1;
   endtask

   function automatic logic [7:0] tx_at(input int i);
      return (i < got_tx.size()) ? got_tx[i] : 8'hxx;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < got_cyc.size()) ? got_cyc[i] : -1;
   endfunction

   function automatic logic [5:0] addr_at(input int i);
      return (i < got_addr.size()) ? got_addr[i] : 6'hxx;
   endfunction

   initial begin
      int strobes;
      int dones;

      for (int i = 0; i < 64; i++) mem[i] = 8'(8'h41 + 3 * i);

      bus.Start = 0;  bus.Abort = 0;  bus.BaseAddress = '0;  bus.Length = '0;
      bus.TxFull = 0; bus.UartTick = 1;
      bus_lf.Start = 0;  bus_lf.Abort = 0;  bus_lf.BaseAddress = '0;
      bus_lf.Length = '0; bus_lf.TxFull = 0; bus_lf.UartTick = 1;
      bus_lf.RAMData = '0;

      // Reset values
      Reset_n = 1'b1;
      #2 Reset_n = 1'b0;
      #1;
      check("rst_ramaddr", 32'(bus.RAMAddress), 32'h0);
      check("rst_txdata",  32'(bus.TxData),     32'h0);
      check("rst_write",   32'(bus.WriteToUart), 32'h0);
      check("rst_busy",    32'(bus.Busy),       32'h0);
      check("rst_done",    32'(bus.Done),       32'h0);
      step(); step();
      Reset_n = 1'b1;
      step();

      // Base 5, length 3, CR/LF
      start_line(6'd5, 6'd3);
      collect(40, 1'b0);
      check("l3_nstrobes", 32'(got_tx.size()), 32'd5);
      check("l3_ch0",      32'(tx_at(0)), 32'h50);
      check("l3_ch1",      32'(tx_at(1)), 32'h53);
      check("l3_ch2",      32'(tx_at(2)), 32'h56);
      check("l3_cr",       32'(tx_at(3)), 32'h0D);
      check("l3_lf",       32'(tx_at(4)), 32'h0A);
      check("l3_latency",  32'(cyc_at(0)), 32'd4);
      check("l3_strobe2",  32'(cyc_at(1)), 32'd7);
      check("l3_cr_cyc",   32'(cyc_at(3)), 32'd12);
      check("l3_lf_cyc",   32'(cyc_at(4)), 32'd14);
      check("l3_done_cyc", 32'(done_cyc),  32'd15);
      check("l3_busy_end", 32'(bus.Busy),  32'h0);
      step();
      check("l3_done_1cyc", 32'(bus.Done), 32'h0);

      // Address wrap: base 62, length 4
      step();
      start_line(6'd62, 6'd4);
      collect(40, 1'b0);
      check("wr_naddr",    32'(got_addr.size()), 32'd4);
      check("wr_addr0",    32'(addr_at(0)), 32'd62);
      check("wr_addr1",    32'(addr_at(1)), 32'd63);
      check("wr_addr2",    32'(addr_at(2)), 32'd0);
      check("wr_addr3",    32'(addr_at(3)), 32'd1);
      check("wr_ch2",      32'(tx_at(2)),   32'h41);
      check("wr_ch3",      32'(tx_at(3)),   32'h44);
      check("wr_done_cyc", 32'(done_cyc),   32'd18);

      // TxFull back-pressure with tick high, then release and single tick
      step();
      start_line(6'd10, 6'd1);
      bus.TxFull = 1'b1;
      strobes = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 1) bus.Start = 1'b0;
         if (bus.WriteToUart) strobes++;
      end
      check("full_no_strobe", 32'(strobes),  32'd0);
      check("full_busy",      32'(bus.Busy), 32'h1);
      bus.TxFull   = 1'b0;
      bus.UartTick = 1'b0;
      step();
      check("full_notick0", 32'(bus.WriteToUart), 32'h0);
      step();
      check("full_notick1", 32'(bus.WriteToUart), 32'h0);
      bus.UartTick = 1'b1;
      step();
      check("full_strobe",  32'(bus.WriteToUart), 32'h1);
      check("full_char",    32'(bus.TxData),      32'h5F);
      collect(20, 1'b0);
      check("full_term_n",  32'(got_tx.size()), 32'd2);
      check("full_term_lf", 32'(tx_at(1)),      32'h0A);
      check("full_done",    32'(done_cyc > 0),  32'h1);

      // Abort after the 2nd of 5 characters
      step();
      start_line(6'd20, 6'd5);
      strobes = 0;
      for (int c = 1; c <= 30 && strobes < 2; c++) begin
         step();
         if (c == 1) bus.Start = 1'b0;
         if (bus.WriteToUart) strobes++;
      end
      check("ab_two_seen", 32'(strobes), 32'd2);
      bus.Abort = 1'b1;
      step();
      bus.Abort = 1'b0;
      check("ab_busy",  32'(bus.Busy),        32'h0);
      check("ab_write", 32'(bus.WriteToUart), 32'h0);
      strobes = 0;
      dones   = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.WriteToUart) strobes++;
         if (bus.Done) dones++;
      end
      check("ab_quiet_wr",   32'(strobes), 32'd0);
      check("ab_quiet_done", 32'(dones),   32'd0);

      // New line after abort, with a Start pulsed while busy
      start_line(6'd30, 6'd2);
      collect(40, 1'b1);
      check("re_nstrobes", 32'(got_tx.size()), 32'd4);
      check("re_ch0",      32'(tx_at(0)), 32'h9B);
      check("re_ch1",      32'(tx_at(1)), 32'h9E);
      check("re_done_cyc", 32'(done_cyc), 32'd12);
      step(); step();
      check("re_idle", 32'(bus.Busy), 32'h0);

      // Abort wins over fire in SEND
      start_line(6'd40, 6'd2);
      step(); bus.Start = 1'b0;
      step(); step();
      bus.Abort = 1'b1;
      step();
      bus.Abort = 1'b0;
      check("abf_write", 32'(bus.WriteToUart), 32'h0);
      check("abf_busy",  32'(bus.Busy),        32'h0);
      check("abf_done",  32'(bus.Done),        32'h0);

      // Abort wins over Start in IDLE
      step();
      start_line(6'd3, 6'd2);
      bus.Abort = 1'b1;
      step();
      bus.Start = 1'b0;
      bus.Abort = 1'b0;
      check("abs_busy", 32'(bus.Busy), 32'h0);
      step();

      // Empty line, LF-only instance
      bus_lf.BaseAddress = 6'd3;
      bus_lf.Length      = 6'd0;
      bus_lf.Start       = 1'b1;
      strobes = 0;
      done_cyc = -1;
      got_tx.delete();
      got_cyc.delete();
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 1) bus_lf.Start = 1'b0;
         if (bus_lf.WriteToUart) begin
            strobes++;
            got_tx.push_back(bus_lf.TxData);
            got_cyc.push_back(c);
         end
         if (bus_lf.Done && done_cyc < 0) done_cyc = c;
      end
      check("lf0_nstrobes", 32'(strobes),   32'd1);
      check("lf0_char",     32'(tx_at(0)),  32'h0A);
      check("lf0_strobe",   32'(cyc_at(0)), 32'd3);
      check("lf0_done",     32'(done_cyc),  32'd4);

      // Asynchronous reset mid-line
      start_line(6'd5, 6'd3);
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c == 1) bus.Start = 1'b0;
      end
      check("mr_pre_busy", 32'(bus.Busy), 32'h1);
      #2 Reset_n = 1'b0;
      #1;
      check("mr_ramaddr", 32'(bus.RAMAddress),  32'h0);
      check("mr_txdata",  32'(bus.TxData),      32'h0);
      check("mr_write",   32'(bus.WriteToUart), 32'h0);
      check("mr_busy",    32'(bus.Busy),        32'h0);
      check("mr_done",    32'(bus.Done),        32'h0);
      step();
      Reset_n = 1'b1;
      strobes = 0;
      dones   = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.WriteToUart || bus.Busy) strobes++;
         if (bus.Done) dones++;
      end
      check("mr_stays_idle", 32'(strobes), 32'd0);
      check("mr_no_done",    32'(dones),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_line_sender.md
RAM_LINE_SENDER -- requirements
Module: ram_line_sender

Interface
REQ-001 Parameter ADDR_WIDTH, default 6, SHALL set the width of the RAM address, base and length.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the width of the RAM data and UART character.
REQ-003 Parameter TERM_MODE, default 2, SHALL select the line terminator: 0 none, 1 LF only, 2 CR then LF.
REQ-004 Clock  in  1  SHALL be the single system clock; all state changes on its rising edge.
REQ-005 Reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 Start  in  1  SHALL be the request to send one line; sampled only in IDLE.
REQ-007 Abort  in  1  SHALL be the request to cancel the transfer in progress.
REQ-008 BaseAddress  in  ADDR_WIDTH  SHALL give the first RAM address; latched on accepted Start.
REQ-009 Length  in  ADDR_WIDTH  SHALL give the number of characters, 0 allowed; latched on accepted Start.
REQ-010 RAMData  in  DATA_WIDTH  SHALL carry the synchronous-RAM read data, valid one cycle after RAMAddress.
REQ-011 TxFull  in  1  SHALL signal that the UART FIFO is full.
REQ-012 UartTick  in  1  SHALL be the UART-rate enable.
REQ-013 RAMAddress  out  ADDR_WIDTH  SHALL be the RAM read address.
REQ-014 TxData  out  DATA_WIDTH  SHALL be the character presented to the UART.
REQ-015 WriteToUart  out  1  SHALL be a one-cycle write strobe.
REQ-016 Busy  out  1  SHALL be high in every state except IDLE.
REQ-017 Done  out  1  SHALL be a one-cycle pulse on normal completion.

Function
REQ-018 The FSM SHALL have states IDLE, ADDR, LOAD, SEND, TERM_CR, TERM_LF and DONE.
REQ-019 IDLE with Start=1 and Abort=0 SHALL latch BaseAddress and Length, clear the character count, and move to ADDR when Length>0.
REQ-020 IDLE with Start=1, Abort=0 and Length=0 SHALL move directly to the first terminator state selected by TERM_MODE, or to DONE when TERM_MODE=0.
REQ-021 ADDR SHALL drive RAMAddress = latched base + count, modulo 2^ADDR_WIDTH, then move to LOAD.
REQ-022 LOAD SHALL capture RAMData into TxData, then move to SEND.
REQ-023 SEND, TERM_CR and TERM_LF SHALL wait until UartTick=1 and TxFull=0 (the fire condition).
REQ-024 On fire, the block SHALL register WriteToUart=1 for exactly the following cycle, with TxData stable during that cycle.
REQ-025 On fire in SEND, the block SHALL increment the count.
REQ-026 After that increment, SEND SHALL go to ADDR if count<Length, else to TERM_CR (mode 2), TERM_LF (mode 1) or DONE (mode 0).
REQ-027 TERM_CR SHALL present TxData=8'h0D and, on fire, go to TERM_LF.
REQ-028 TERM_LF SHALL present TxData=8'h0A and, on fire, go to DONE.
REQ-029 DONE SHALL assert Done for one cycle and return to IDLE.
REQ-030 Fire SHALL be impossible on a cycle with TxFull=1, even when UartTick=1.
REQ-031 WriteToUart strobes SHALL be at least two cycles apart.
REQ-032 Abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with WriteToUart=0 and no Done.
REQ-033 Abort SHALL win over Start when both are 1 in IDLE, and over fire when both occur in the same cycle.
REQ-034 Start while Busy=1 SHALL be ignored.
REQ-035 Address arithmetic SHALL wrap from 2^ADDR_WIDTH-1 to 0 without error.
REQ-036 Latency from accepted Start (cycle N) to the first WriteToUart, with UartTick=1 and TxFull=0 throughout, SHALL be 4 cycles (high in cycle N+4).

Reset
REQ-037 Reset_n=0 SHALL asynchronously force the FSM to IDLE and clear all outputs (RAMAddress=0, TxData=0, WriteToUart=0, Busy=0, Done=0), the latched base, length and count.
REQ-038 Reset asserted mid-line SHALL abandon the line; after release the block SHALL idle until a new Start.

Structure
REQ-039 The state encoding and the CR (8'h0D) and LF (8'h0A) constants SHALL reside in the shared package uart_pkg.
REQ-040 The block SHALL be a single module with no sub-modules, the RAM being external.

Verification
REQ-041 Base=5, Length=3, mode 2, tick always high, TxFull=0 -> 5 strobes with TxData = RAM[5], RAM[6], RAM[7], 0D, 0A; Done one cycle after the last strobe.
REQ-042 Base=62, Length=4, ADDR_WIDTH=6 -> RAMAddress sequence 62, 63, 0, 1.
REQ-043 Length=0, mode 1 -> exactly one strobe with TxData=0A, then Done.
REQ-044 TxFull held high for 10 cycles during SEND, tick high -> no strobe until TxFull falls; then one strobe on the next tick.
REQ-045 Abort asserted after the 2nd of 5 characters -> next edge Busy=0; no further strobes; no Done; a new Start then works normally.
REQ-046 Reset_n pulsed low mid-line -> all outputs 0 immediately, even without a clock edge.
